// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider (signed/unsigned) answering a start/ready handshake.
// Optional macro DIV_ZERO_FLAG_EN adds a registered div_zero_o flag alongside ready_o.
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
`ifdef DIV_ZERO_FLAG_EN
    output logic               ready_o,
    output logic               div_zero_o
`else
    output logic               ready_o
`endif
);

    typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
    logic               neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0] result_d;
    logic               ready_d;

    // Operand magnitudes used at capture; unsigned operands pass through untouched.
    logic [WIDTH-1:0] mag1, mag2;
    assign mag1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign mag2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    // One restoring step: the shifted partial remainder can need WIDTH+1 bits.
    logic [WIDTH:0]   part, diff;
    logic [WIDTH-1:0] step_rem, step_quo, fix_rem, fix_quo;
    assign part     = {rem_q, quo_q[WIDTH-1]};
    assign diff     = part - {1'b0, dvsr_q};
    assign step_rem = diff[WIDTH] ? part[WIDTH-1:0] : diff[WIDTH-1:0];
    assign step_quo = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    assign fix_quo  = neg_quo_q ? -step_quo : step_quo;
    assign fix_rem  = neg_rem_q ? -step_rem : step_rem;

    logic last_step, abort;
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));
    assign abort     = annul_i || !start_i;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_o;
        ready_d   = ready_o;
        unique case (state_q)
            S_FREE: begin
                result_d = '0;
                ready_d  = 1'b0;
                if (start_i && !annul_i) begin
                    rem_d     = '0;
                    quo_d     = mag1;
                    dvsr_d    = mag2;
                    neg_quo_d = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    neg_rem_d = signed_div_i && opdata1_i[WIDTH-1];
                    cnt_d     = '0;
                    state_d   = (opdata2_i == '0) ? S_BYZERO : S_ON;
                end
            end
            S_BYZERO: begin
                result_d = '0;
                ready_d  = 1'b1;
                state_d  = S_END;
            end
            S_ON: begin
                if (abort) begin
                    result_d = '0;
                    ready_d  = 1'b0;
                    state_d  = S_FREE;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_step) begin
                        result_d = {fix_rem, fix_quo};
                        ready_d  = 1'b1;
                        state_d  = S_END;
                    end
                end
            end
            S_END: begin
                if (abort) begin
                    result_d = '0;
                    ready_d  = 1'b0;
                    state_d  = S_FREE;
                end
            end
            default: state_d = S_FREE;
        endcase
    end

    // NOTE: datapath registers are reset as well, so nothing downstream ever sees X after reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_FREE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_o  <= '0;
            ready_o   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_o  <= result_d;
            ready_o   <= ready_d;
        end
    end

`ifdef DIV_ZERO_FLAG_EN
    // Set on the BYZERO->END edge, held through END, cleared when END is left.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_zero_o <= 1'b0;
        end else begin
            div_zero_o <= (state_d == S_END) && (state_q == S_BYZERO || div_zero_o);
        end
    end
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table plus scoreboard, with hand-written
// sequences for annul, start-drop, busy-annul and asynchronous reset.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        resetn;
    logic        signed_div_i;
    logic [31:0] opdata1_i, opdata2_i;
    logic        start_i, annul_i;
    logic [63:0] result_o;
    logic        ready_o;
`ifdef DIV_ZERO_FLAG_EN
    logic        div_zero_o;
`endif

    int checks   = 0;
    int failures = 0;
    logic [63:0] sb_q[$];

    seq_divider #(.WIDTH(32), .CNT_W(6)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
`ifdef DIV_ZERO_FLAG_EN
        .ready_o      (ready_o),
        .div_zero_o   (div_zero_o)
`else
        .ready_o      (ready_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          s;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model built on the simulator's own / and % operators.
    function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
        int sa, sb, q, r;
        if (b == 32'h0) return 64'h0;
        if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            sa = a;
            sb = b;
            q  = sa / sb;
            r  = sa % sb;
            return {r, q};
        end
        return {a % b, a / b};
    endfunction

    // Called at a negedge; returns at a negedge with start_i low and the DUT back in FREE.
    task automatic run_op(input string name, input bit s, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        int   edges;
        bit   got;
        int   exp_lat;
        logic [63:0] want;
        exp_lat = (b == 32'h0) ? 2 : 33;
        sb_q.push_back(exp);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        edges = 0;
        got   = 1'b0;
        while (edges < 100 && !got) begin
            @(posedge clk);
            edges++;
            #1;
            // Scramble operands after capture; the DUT must ignore them.
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            got = ready_o;
        end
        check({name, " latency"}, 64'(edges), 64'(exp_lat));
        want = sb_q.pop_front();
        if (!got) begin
            start_i = 1'b0;
            repeat (3) @(negedge clk);
            return;
        end
        check({name, " result"}, result_o, want);
`ifdef DIV_ZERO_FLAG_EN
        check({name, " div_zero"}, 64'(div_zero_o), 64'(b == 32'h0));
`endif
        @(negedge clk);
        check({name, " hold"}, {ready_o, result_o[62:0]}, {1'b1, want[62:0]});
        start_i = 1'b0;
        @(negedge clk);
        check({name, " clear"}, {63'h0, ready_o} | result_o, 64'h0);
`ifdef DIV_ZERO_FLAG_EN
        check({name, " div_zero clear"}, 64'(div_zero_o), 64'h0);
`endif
    endtask

    // Starts 100/7 and returns at the negedge just before the edge performing step k.
    task automatic start_and_step(input int k);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        repeat (k) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int  seen;
        bit  got;
        bit  s;
        logic [31:0] a, b;

        vecs[0]  = '{1'b0, 32'd7,         32'd2,         {32'h0000_0001, 32'h0000_0003}};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD}};
        vecs[2]  = '{1'b0, 32'hFFFF_FFF9, 32'd2,         {32'h0000_0001, 32'h7FFF_FFFC}};
        vecs[3]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}};
        vecs[4]  = '{1'b0, 32'd100,       32'd7,         {32'h0000_0002, 32'h0000_000E}};
        vecs[5]  = '{1'b1, 32'd7,         32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}};
        vecs[6]  = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, {32'hFFFF_FFFF, 32'h0000_0003}};
        vecs[7]  = '{1'b0, 32'hFFFF_FFFF, 32'd1,         {32'h0000_0000, 32'hFFFF_FFFF}};
        vecs[8]  = '{1'b0, 32'd5,         32'd9,         {32'h0000_0005, 32'h0000_0000}};
        vecs[9]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'h0000_0000, 32'h0000_0001}};
        vecs[10] = '{1'b1, 32'h8000_0000, 32'd1,         {32'h0000_0000, 32'h8000_0000}};
        vecs[11] = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0000_0000}};
        vecs[12] = '{1'b0, 32'd5,         32'd0,         64'h0};
        vecs[13] = '{1'b1, 32'h8000_0000, 32'd0,         64'h0};

        resetn = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        start_i = 1'b0;
        annul_i = 1'b0;
        #2;
        check("reset state", {63'h0, ready_o} | result_o, 64'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        for (int i = 0; i < 8; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (b == 32'h0) b = 32'd3;
            run_op($sformatf("rand%0d", i), s, a, b, model(s, a, b));
        end

        // Annul during step 10; annul and start stay high, which must not recapture.
        start_and_step(10);
        annul_i = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) seen++;
        end
        check("annul no ready", 64'(seen), 64'h0);
        annul_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        run_op("after annul", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14});

        // Start dropped during step 20.
        start_and_step(20);
        start_i = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) seen++;
        end
        check("start drop no ready", 64'(seen), 64'h0);
        run_op("after drop", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14});

        // Asynchronous reset during step 15.
        start_and_step(15);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("reset in ON", {63'h0, ready_o} | result_o, 64'h0);
        start_i = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        run_op("after reset", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3});

        // Asynchronous reset while a result is being held in END.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd7;
        opdata2_i    = 32'd2;
        start_i      = 1'b1;
        got = 1'b0;
        for (int e = 0; e < 100 && !got; e++) begin
            @(negedge clk);
            got = ready_o;
        end
        check("end before reset", {63'h0, ready_o}, 64'h1);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("reset in END", {63'h0, ready_o} | result_o, 64'h0);
        start_i = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        run_op("post end reset", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

        check("scoreboard empty", 64'(sb_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
